// File: rtl/decode_imm_ctrl_pkg.sv
// Shared types for the decode/immediate-extension stage:
// FSM state encoding, extension select codes and the HALT opcode.
package decode_imm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [2:0] SEL_ZX5  = 3'b000;
    localparam logic [2:0] SEL_ZX8  = 3'b001;
    localparam logic [2:0] SEL_SX5  = 3'b010;
    localparam logic [2:0] SEL_SX8  = 3'b100;
    localparam logic [2:0] SEL_SX11 = 3'b110;

    localparam logic [4:0] OP_HALT = 5'b00000;

endpackage

// File: rtl/decode_imm_ctrl_if.sv
// Fetch-side and execute-side handshake bundle for decode_imm_ctrl.
// master = instruction source / sink driver, slave = decode stage.
interface decode_imm_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [15:0]      in_instr;
    logic             in_ready;
    logic             out_ready;
    logic             flush;
    logic             out_valid;
    logic [15:0]      out_instr;
    logic [2:0]       out_sel;
    logic [15:0]      out_imm;
    logic             out_halt;
    logic             halted;
    logic [CNT_W-1:0] issue_cnt;

    modport master (
        output in_valid, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_instr, out_sel,
        input  out_imm, out_halt, halted, issue_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready, flush,
        output in_ready, out_valid, out_instr, out_sel,
        output out_imm, out_halt, halted, issue_cnt
    );
endinterface

// File: rtl/decode_imm_ctrl_imm_ext.sv
// imm_ext: combinational opcode -> extension select and immediate.
// Ports: instr[15:0] in; sel[2:0], imm[15:0] out.
module imm_ext
    import decode_imm_ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output logic [2:0]  sel,
    output logic [15:0] imm
);

    logic [4:0] op;
    assign op = instr[15:11];

    always_comb begin
        sel = SEL_ZX5;
        case (op)
            5'b10010:
                sel = SEL_ZX8;
            5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011:
                sel = SEL_SX5;
            5'b01100, 5'b01101, 5'b01110, 5'b01111,
            5'b11000, 5'b00101, 5'b00111:
                sel = SEL_SX8;
            5'b00100, 5'b00110:
                sel = SEL_SX11;
            default:
                sel = SEL_ZX5;
        endcase
    end

    always_comb begin
        imm = '0;
        case (sel)
            SEL_ZX8:  imm = {8'h00, instr[7:0]};
            SEL_SX5:  imm = {{11{instr[4]}}, instr[4:0]};
            SEL_SX8:  imm = {{8{instr[7]}}, instr[7:0]};
            SEL_SX11: imm = {{5{instr[10]}}, instr[10:0]};
            default:  imm = {11'h000, instr[4:0]};
        endcase
    end

endmodule

// File: rtl/decode_imm_ctrl.sv
// Decode stage: one-entry output register holding the decoded
// instruction, EMPTY/FULL/HALTED control and an issue counter.
// Ports: clk, rst (sync, active high), bus (slave handshake bundle).
module decode_imm_ctrl
    import decode_imm_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    decode_imm_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [15:0]      instr_q;
    logic [2:0]       sel_q;
    logic [15:0]      imm_q;
    logic             halt_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]  dec_sel;
    logic [15:0] dec_imm;
    logic        in_rdy;
    logic        accept;
    logic        issue;

    imm_ext u_imm_ext (
        .instr (bus.in_instr),
        .sel   (dec_sel),
        .imm   (dec_imm)
    );

    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        case (state_q)
            ST_EMPTY: in_rdy = 1'b1;
            // Nothing may enter behind a held HALT.
            ST_FULL:  in_rdy = bus.out_ready & ~halt_q;
            default:  in_rdy = 1'b0;
        endcase

        accept = bus.in_valid & in_rdy & ~bus.flush;
        issue  = (state_q == ST_FULL) & bus.out_ready & ~bus.flush;

        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (issue) begin
                    if (halt_q)      state_d = ST_HALTED;
                    else if (accept) state_d = ST_FULL;
                    else             state_d = ST_EMPTY;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_EMPTY;
        endcase

        if (bus.flush) state_d = ST_EMPTY;

        cnt_d = issue ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            sel_q   <= SEL_ZX5;
            imm_q   <= '0;
            halt_q  <= 1'b0;
        end else if (accept) begin
            instr_q <= bus.in_instr;
            sel_q   <= dec_sel;
            imm_q   <= dec_imm;
            halt_q  <= (bus.in_instr[15:11] == OP_HALT);
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.halted    = (state_q == ST_HALTED);
    assign bus.out_instr = instr_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_imm   = imm_q;
    assign bus.out_halt  = halt_q;
    assign bus.issue_cnt = cnt_q;

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Self-checking bench for decode_imm_ctrl: directed scenarios plus
// randomized traffic checked against a behavioural model.
module tb_decode_imm_ctrl;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    decode_imm_ctrl_if #(.CNT_W(CW)) bus ();

    decode_imm_ctrl #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bit          m_has;
    bit          m_halted;
    logic [15:0] m_instr;
    int          m_cnt;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_dec(input logic [15:0] ins,
                                    output logic [2:0] s,
                                    output logic [15:0] imm);
        int op;
        int v;
        op = int'(ins[15:11]);
        if (op == 18) begin
            s = 3'b001;
            v = int'(ins[7:0]);
        end else if (op inside {8, 9, 16, 17, 19}) begin
            s = 3'b010;
            v = int'(ins[4:0]);
            if (v >= 16) v = v - 32;
        end else if (op inside {[12:15], 24, 5, 7}) begin
            s = 3'b100;
            v = int'(ins[7:0]);
            if (v >= 128) v = v - 256;
        end else if (op inside {4, 6}) begin
            s = 3'b110;
            v = int'(ins[10:0]);
            if (v >= 1024) v = v - 2048;
        end else begin
            s = 3'b000;
            v = int'(ins[4:0]);
        end
        imm = v[15:0];
    endfunction

    task automatic step(input logic r, input logic v,
                        input logic [15:0] ins, input logic ordy,
                        input logic fl);
        logic        exp_rdy;
        bit          acc;
        bit          iss;
        logic [2:0]  es;
        logic [15:0] ei;
        rst           = r;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        if (m_halted)    exp_rdy = 1'b0;
        else if (!m_has) exp_rdy = 1'b1;
        else             exp_rdy = ordy && (m_instr[15:11] != 5'd0);
        chk("in_ready", {15'd0, bus.in_ready}, {15'd0, exp_rdy});
        acc = v && exp_rdy && !fl;
        iss = m_has && ordy && !fl;
        @(posedge clk);
        #1;
        if (r) begin
            m_has = 0; m_halted = 0; m_cnt = 0;
        end else if (fl) begin
            m_has = 0; m_halted = 0;
        end else if (!m_halted) begin
            if (iss) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                m_has = 0;
                if (m_instr[15:11] == 5'd0) m_halted = 1;
            end
            if (acc) begin
                m_has = 1; m_instr = ins;
            end
        end
        chk("out_valid", {15'd0, bus.out_valid}, {15'd0, m_has});
        chk("halted", {15'd0, bus.halted}, {15'd0, m_halted});
        chk("issue_cnt", {12'd0, bus.issue_cnt}, 16'(m_cnt));
        if (m_has) begin
            ref_dec(m_instr, es, ei);
            chk("out_instr", bus.out_instr, m_instr);
            chk("out_sel", {13'd0, bus.out_sel}, {13'd0, es});
            chk("out_imm", bus.out_imm, ei);
            chk("out_halt", {15'd0, bus.out_halt},
                {15'd0, m_instr[15:11] == 5'd0});
        end
        if (r) begin
            chk("rst_instr", bus.out_instr, 16'h0000);
            chk("rst_sel", {13'd0, bus.out_sel}, 16'h0000);
            chk("rst_imm", bus.out_imm, 16'h0000);
            chk("rst_halt", {15'd0, bus.out_halt}, 16'h0000);
        end
    endtask

    logic [15:0] vec_in  [4];
    logic [2:0]  vec_sel [4];
    logic [15:0] vec_imm [4];
    logic [15:0] rnd;

    initial begin
        m_has = 0; m_halted = 0; m_instr = '0; m_cnt = 0;
        vec_in[0] = 16'h401F; vec_sel[0] = 3'b010; vec_imm[0] = 16'hFFFF;
        vec_in[1] = 16'h2400; vec_sel[1] = 3'b110; vec_imm[1] = 16'hFC00;
        vec_in[2] = 16'h9080; vec_sel[2] = 3'b001; vec_imm[2] = 16'h0080;
        vec_in[3] = 16'hC080; vec_sel[3] = 3'b100; vec_imm[3] = 16'hFF80;

        step(1, 0, 16'h0, 1, 0);
        step(0, 0, 16'h0, 1, 0);

        for (int i = 0; i < 4; i++) begin
            step(0, 1, vec_in[i], 1, 0);
            chk("vec_sel", {13'd0, bus.out_sel}, {13'd0, vec_sel[i]});
            chk("vec_imm", bus.out_imm, vec_imm[i]);
            step(0, 0, 16'h0, 1, 0);
        end

        step(1, 0, 16'h0, 1, 0);
        step(0, 1, 16'h401F, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 16'h9080, 0, 0);
            chk("stall_hold", bus.out_instr, 16'h401F);
        end
        step(0, 1, 16'h9080, 1, 0);
        chk("b2b_instr", bus.out_instr, 16'h9080);
        chk("b2b_valid", {15'd0, bus.out_valid}, 16'd1);
        step(0, 0, 16'h0, 1, 0);
        chk("b2b_cnt", {12'd0, bus.issue_cnt}, 16'd2);

        step(1, 0, 16'h0, 1, 0);
        step(0, 1, 16'h0000, 1, 0);
        chk("halt_flag", {15'd0, bus.out_halt}, 16'd1);
        step(0, 1, 16'h401F, 1, 0);
        step(0, 1, 16'h401F, 1, 0);
        chk("halt_state", {15'd0, bus.halted}, 16'd1);
        chk("halt_cnt", {12'd0, bus.issue_cnt}, 16'd1);
        step(0, 0, 16'h0, 1, 1);
        chk("unhalt_rdy", {15'd0, bus.in_ready}, 16'd1);

        step(1, 0, 16'h0, 1, 0);
        step(0, 1, 16'hC080, 1, 0);
        step(0, 1, 16'h9080, 1, 1);
        chk("flush_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("flush_cnt", {12'd0, bus.issue_cnt}, 16'd0);

        step(1, 0, 16'h0, 1, 0);
        for (int i = 0; i < 17; i++) begin
            rnd = 16'($urandom);
            if (rnd[15:11] == 5'd0) rnd[15:11] = 5'd1;
            step(0, 1, rnd, 1, 0);
        end
        step(0, 0, 16'h0, 1, 0);
        chk("wrap_cnt", {12'd0, bus.issue_cnt}, 16'd1);
        step(0, 1, 16'h2400, 0, 0);
        step(1, 1, 16'h2400, 0, 0);
        chk("rst_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_cnt", {12'd0, bus.issue_cnt}, 16'd0);

        for (int i = 0; i < 400; i++) begin
            rnd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rnd[15:11] = 5'd0;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 rnd,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
